fc_result_collector: RTL and testbench

Downstream stage of the fully-connected vector multiplier. Each multiplier result arrives with its 3-bit phase (output-neuron index). The block adds a per-phase bias, saturates to DW, applies optional ReLU and buffers the results by phase. Once all NOUT results are present, it streams them out in index order over valid/ready and reports the argmax (classification result).

---
 rtl/fc_pkg.sv | 25 ++
 rtl/fc_bias_sat_relu.sv | 60 ++++++
 rtl/fc_result_collector.sv | 129 ++++++++++++
 tb/tb_fc_result_collector.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared types and constants for the fully-connected result collector.
// sat_add is the reference saturating add at the default data width.
package fc_pkg;

  localparam int DW      = 24;
  localparam int PHASE_W = 3;

  localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } fc_state_e;

  // Overflow shows up as the top two bits of the DW+1 sum disagreeing.
  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] sum;
    sum = {a[DW-1], a} + {b[DW-1], b};
    if (sum[DW] != sum[DW-1]) sat_add = sum[DW] ? SAT_MIN : SAT_MAX;
    else                      sat_add = sum[DW-1:0];
  endfunction

endpackage

// File: rtl/fc_bias_sat_relu.sv
// Bias register file plus the bias-add/saturate stage; the ReLU stage is
// presented combinationally so the collector's buffer write is stage 2.
module fc_bias_sat_relu
  import fc_pkg::*;
#(
  parameter int DW = fc_pkg::DW
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               bias_we_i,
  input  logic [PHASE_W-1:0] bias_addr_i,
  input  logic [DW-1:0]      bias_data_i,
  input  logic               in_valid_i,
  input  logic [PHASE_W-1:0] in_phase_i,
  input  logic [DW-1:0]      in_data_i,
  input  logic               relu_en_i,
  output logic               out_valid_o,
  output logic [PHASE_W-1:0] out_phase_o,
  output logic [DW-1:0]      out_data_o
);

  localparam int NB = 1 << PHASE_W;

  logic [DW-1:0]      bias_q [NB];
  logic               s1_valid_q;
  logic [PHASE_W-1:0] s1_phase_q;
  logic [DW-1:0]      s1_data_q;
  logic [DW:0]        sum_w;
  logic [DW-1:0]      sat_w;

  always_comb begin
    sum_w = {in_data_i[DW-1], in_data_i} + {bias_q[in_phase_i][DW-1], bias_q[in_phase_i]};
    sat_w = sum_w[DW-1:0];
    if (sum_w[DW] != sum_w[DW-1])
      sat_w = sum_w[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end

  // A bias written this cycle is only seen by inputs from the next cycle on.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NB; i++) bias_q[i] <= '0;
      s1_valid_q <= 1'b0;
      s1_phase_q <= '0;
      s1_data_q  <= '0;
    end else begin
      if (bias_we_i) bias_q[bias_addr_i] <= bias_data_i;
      s1_valid_q <= in_valid_i && !flush_i;
      if (in_valid_i) begin
        s1_phase_q <= in_phase_i;
        s1_data_q  <= sat_w;
      end
    end
  end

  assign out_valid_o = s1_valid_q && !flush_i;
  assign out_phase_o = s1_phase_q;
  assign out_data_o  = (relu_en_i && s1_data_q[DW-1]) ? '0 : s1_data_q;

endmodule

// File: rtl/fc_result_collector.sv
// Collects one frame of per-phase results, then streams them in index order
// (RES_VALID/RES_READY: a beat transfers on a rising edge where both are 1) and reports the argmax.
module fc_result_collector
  import fc_pkg::*;
#(
  parameter int DW   = fc_pkg::DW,
  parameter int NOUT = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          DIN_VALID,
  input  logic [DW-1:0] DIN,
  input  logic [2:0]    DIN_PHASE,
  input  logic          B_WEN,
  input  logic [2:0]    B_ADDR,
  input  logic [DW-1:0] B_WDATA,
  input  logic          RELU_EN,
  input  logic          START,
  output logic          RES_VALID,
  input  logic          RES_READY,
  output logic [DW-1:0] RES_DATA,
  output logic [2:0]    RES_IDX,
  output logic          MAX_VALID,
  output logic [2:0]    MAX_IDX,
  output logic [DW-1:0] MAX_VAL,
  output logic          BUSY,
  output logic          DUP_ERR,
  output logic          DROP_ERR
);

  localparam logic [PHASE_W:0]   NOUT_L    = (PHASE_W+1)'(NOUT);
  localparam logic [7:0]         FULL_MASK = 8'((1 << NOUT) - 1);
  localparam logic [PHASE_W-1:0] LAST_IDX  = PHASE_W'(NOUT - 1);

  fc_state_e          state_q;
  logic [7:0]         bitmap_q, bitmap_d;
  logic [DW-1:0]      buf_q [8];
  logic [PHASE_W-1:0] idx_q, run_idx_q, max_idx_q, new_idx_w;
  logic [DW-1:0]      run_val_q, max_val_q, new_val_w, cur_w;
  logic               dup_q, drop_q;
  logic               in_range_w, accept_w, drop_w, take_w;
  logic               s2_valid_w;
  logic [PHASE_W-1:0] s2_phase_w;
  logic [DW-1:0]      s2_data_w;

  assign in_range_w = {1'b0, DIN_PHASE} < NOUT_L;
  assign accept_w   = DIN_VALID && !START && (state_q == COLLECT) && in_range_w;
  assign drop_w     = DIN_VALID && !START && !((state_q == COLLECT) && in_range_w);

  fc_bias_sat_relu #(.DW(DW)) u_pipe (
    .clk_i       (CLK),
    .rst_i       (RST),
    .flush_i     (START),
    .bias_we_i   (B_WEN),
    .bias_addr_i (B_ADDR),
    .bias_data_i (B_WDATA),
    .in_valid_i  (accept_w),
    .in_phase_i  (DIN_PHASE),
    .in_data_i   (DIN),
    .relu_en_i   (RELU_EN),
    .out_valid_o (s2_valid_w),
    .out_phase_o (s2_phase_w),
    .out_data_o  (s2_data_w)
  );

  // Running argmax: the first beat seeds it, later beats need strictly greater.
  assign cur_w     = buf_q[idx_q];
  assign take_w    = (idx_q == '0) || ($signed(cur_w) > $signed(run_val_q));
  assign new_idx_w = take_w ? idx_q : run_idx_q;
  assign new_val_w = take_w ? cur_w : run_val_q;

  always_comb begin
    bitmap_d = (state_q == DONE) ? '0 : bitmap_q;
    if (s2_valid_w) bitmap_d[s2_phase_w] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST || START) begin
      state_q   <= COLLECT;
      bitmap_q  <= '0;
      idx_q     <= '0;
      run_idx_q <= '0;
      run_val_q <= '0;
      max_idx_q <= '0;
      max_val_q <= '0;
      dup_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      if (drop_w) drop_q <= 1'b1;
      if (s2_valid_w) begin
        buf_q[s2_phase_w] <= s2_data_w;
        if (bitmap_q[s2_phase_w] && state_q != DONE) dup_q <= 1'b1;
      end
      bitmap_q <= bitmap_d;
      case (state_q)
        COLLECT: if ((bitmap_q & FULL_MASK) == FULL_MASK) state_q <= DRAIN;
        DRAIN: begin
          if (RES_READY) begin
            run_idx_q <= new_idx_w;
            run_val_q <= new_val_w;
            idx_q     <= idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
              state_q   <= DONE;
              idx_q     <= '0;
              max_idx_q <= new_idx_w;
              max_val_q <= new_val_w;
            end
          end
        end
        DONE: begin
          state_q <= COLLECT;
          idx_q   <= '0;
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign RES_VALID = (state_q == DRAIN);
  assign RES_DATA  = RES_VALID ? cur_w : '0;
  assign RES_IDX   = RES_VALID ? idx_q : '0;
  assign MAX_VALID = (state_q == DONE);
  assign MAX_IDX   = max_idx_q;
  assign MAX_VAL   = max_val_q;
  assign BUSY      = (state_q != COLLECT);
  assign DUP_ERR   = dup_q;
  assign DROP_ERR  = drop_q;

endmodule

// File: tb/tb_fc_result_collector.sv
// Directed bench for fc_result_collector: hand-computed frames checked
// through an expected-beat queue, plus a NOUT=4 instance for range drops.
module tb_fc_result_collector;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst, din_valid, b_wen, relu_en, start, res_ready;
  logic [DW-1:0] din, b_wdata;
  logic [2:0]    din_phase, b_addr;
  logic          res_valid, max_valid, busy, dup_err, drop_err;
  logic [DW-1:0] res_data, max_val;
  logic [2:0]    res_idx, max_idx;
  logic          n4_res_valid, n4_max_valid, n4_busy, n4_dup_err, n4_drop_err;
  logic [DW-1:0] n4_res_data, n4_max_val;
  logic [2:0]    n4_res_idx, n4_max_idx;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fc_result_collector #(.DW(DW), .NOUT(8)) u_dut (
    .CLK(clk), .RST(rst), .DIN_VALID(din_valid), .DIN(din), .DIN_PHASE(din_phase),
    .B_WEN(b_wen), .B_ADDR(b_addr), .B_WDATA(b_wdata), .RELU_EN(relu_en), .START(start),
    .RES_VALID(res_valid), .RES_READY(res_ready), .RES_DATA(res_data), .RES_IDX(res_idx),
    .MAX_VALID(max_valid), .MAX_IDX(max_idx), .MAX_VAL(max_val), .BUSY(busy),
    .DUP_ERR(dup_err), .DROP_ERR(drop_err)
  );

  fc_result_collector #(.DW(DW), .NOUT(4)) u_dut4 (
    .CLK(clk), .RST(rst), .DIN_VALID(din_valid), .DIN(din), .DIN_PHASE(din_phase),
    .B_WEN(b_wen), .B_ADDR(b_addr), .B_WDATA(b_wdata), .RELU_EN(relu_en), .START(start),
    .RES_VALID(n4_res_valid), .RES_READY(res_ready), .RES_DATA(n4_res_data), .RES_IDX(n4_res_idx),
    .MAX_VALID(n4_max_valid), .MAX_IDX(n4_max_idx), .MAX_VAL(n4_max_val), .BUSY(n4_busy),
    .DUP_ERR(n4_dup_err), .DROP_ERR(n4_drop_err)
  );

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers (enter and leave at a falling edge) ----------------
  task automatic write_bias(input logic [2:0] a, input logic [DW-1:0] v);
    b_wen = 1'b1; b_addr = a; b_wdata = v;
    @(negedge clk);
    b_wen = 1'b0;
  endtask

  task automatic send(input logic [2:0] ph, input logic [DW-1:0] v);
    din_valid = 1'b1; din_phase = ph; din = v;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_busy();
    for (int t = 0; t < 20 && !busy; t++) @(negedge clk);
    check_eq("wait_busy", 32'(busy), 32'd1);
  endtask

  // Consumes exp_q beat by beat, checks stall stability, then the argmax pulse.
  task automatic drain(input bit toggle, input logic [2:0] exp_mi, input logic [DW-1:0] exp_mv);
    int            k = 0;
    int            budget = 0;
    bit            held = 1'b0;
    logic [DW-1:0] hd = '0;
    logic [2:0]    hi = '0;
    while (exp_q.size() > 0 && budget < 300) begin
      res_ready = toggle ? ~res_ready : 1'b1;
      if (held) begin
        check_eq("stall_valid", 32'(res_valid), 32'd1);
        check_eq("stall_data", 32'(res_data), 32'(hd));
        check_eq("stall_idx", 32'(res_idx), 32'(hi));
        held = 1'b0;
      end
      if (res_valid && res_ready) begin
        check_eq("beat_data", 32'(res_data), 32'(exp_q.pop_front()));
        check_eq("beat_idx", 32'(res_idx), 32'(k));
        k++;
      end else if (res_valid) begin
        held = 1'b1; hd = res_data; hi = res_idx;
      end
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    check_eq("max_valid", 32'(max_valid), 32'd1);
    check_eq("max_idx", 32'(max_idx), 32'(exp_mi));
    check_eq("max_val", 32'(max_val), 32'(exp_mv));
    check_eq("busy_done", 32'(busy), 32'd1);
    res_ready = 1'b1;
    @(negedge clk);
    check_eq("max_valid_end", 32'(max_valid), 32'd0);
    check_eq("busy_idle", 32'(busy), 32'd0);
    check_eq("max_idx_hold", 32'(max_idx), 32'(exp_mi));
    check_eq("max_val_hold", 32'(max_val), 32'(exp_mv));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] v;
    logic [DW-1:0] tie_vals [8];
    logic [2:0]    ooo_ph   [9];
    bit            seen;

    rst = 1'b1; din_valid = 1'b0; din = '0; din_phase = '0; b_wen = 1'b0; b_addr = '0;
    b_wdata = '0; relu_en = 1'b0; start = 1'b0; res_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check_eq("rst_res_valid", 32'(res_valid), 32'd0);
    check_eq("rst_res_data", 32'(res_data), 32'd0);
    check_eq("rst_res_idx", 32'(res_idx), 32'd0);
    check_eq("rst_max_valid", 32'(max_valid), 32'd0);
    check_eq("rst_max_idx", 32'(max_idx), 32'd0);
    check_eq("rst_max_val", 32'(max_val), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_dup", 32'(dup_err), 32'd0);
    check_eq("rst_drop", 32'(drop_err), 32'd0);

    // Basic frame: bias 10*i, inputs 100*(i+1).
    for (int i = 0; i < 8; i++) write_bias(3'(i), DW'(10 * i));
    for (int i = 0; i < 8; i++) begin
      send(3'(i), DW'(100 * (i + 1)));
      exp_q.push_back(DW'(100 * (i + 1) + 10 * i));
    end
    drain(1'b0, 3'd7, DW'(870));
    check_eq("basic_dup", 32'(dup_err), 32'd0);
    check_eq("basic_drop", 32'(drop_err), 32'd0);

    // Saturation both ways, then the same frame with ReLU.
    write_bias(3'd3, 24'h7FFFFF);
    write_bias(3'd4, 24'h800000);
    for (int r = 0; r < 2; r++) begin
      relu_en = (r == 1);
      for (int i = 0; i < 8; i++) begin
        v = (i == 3) ? 24'd1 : (i == 4) ? 24'hFFFFFB : 24'd0;
        send(3'(i), v);
        if (i == 3)      exp_q.push_back(24'h7FFFFF);
        else if (i == 4) exp_q.push_back((r == 1) ? 24'h000000 : 24'h800000);
        else             exp_q.push_back(DW'(10 * i));
      end
      drain(1'b0, 3'd3, 24'h7FFFFF);
    end
    relu_en = 1'b0;

    // Backpressure and ties, with negatives to exercise the signed compare.
    for (int i = 0; i < 8; i++) write_bias(3'(i), '0);
    tie_vals = '{24'd5, 24'd9, 24'd9, 24'd2, 24'hFFFFFF, 24'd0, 24'hFFFFF9, 24'd4};
    for (int i = 0; i < 8; i++) begin
      send(3'(i), tie_vals[i]);
      exp_q.push_back(tie_vals[i]);
    end
    drain(1'b1, 3'd1, 24'd9);

    // Out-of-order arrival with phase 3 written twice.
    ooo_ph = '{3'd7, 3'd0, 3'd3, 3'd3, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
    for (int i = 0; i < 9; i++) send(ooo_ph[i], (i == 2) ? DW'(999) : DW'(ooo_ph[i] * 11 + 1));
    check_eq("ooo_dup_set", 32'(dup_err), 32'd1);
    for (int i = 0; i < 8; i++) exp_q.push_back(DW'(i * 11 + 1));
    drain(1'b0, 3'd7, DW'(78));
    check_eq("dup_sticky", 32'(dup_err), 32'd1);
    pulse_start();
    check_eq("dup_cleared", 32'(dup_err), 32'd0);

    // Input during DRAIN is dropped and leaves the buffer alone.
    res_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(3'(i), DW'(3 * (i + 1)));
      exp_q.push_back(DW'(3 * (i + 1)));
    end
    wait_busy();
    send(3'd2, 24'h5555);
    check_eq("drain_drop", 32'(drop_err), 32'd1);
    drain(1'b0, 3'd7, DW'(24));
    check_eq("drop_sticky", 32'(drop_err), 32'd1);

    // START after three accepted beats abandons the frame.
    res_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(3'(i), DW'(1000 + i));
    wait_busy();
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("mid_idx", 32'(res_idx), 32'd3);
    check_eq("mid_data", 32'(res_data), 32'd1003);
    start = 1'b1; res_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check_eq("start_res_valid", 32'(res_valid), 32'd0);
    check_eq("start_busy", 32'(busy), 32'd0);
    check_eq("start_drop", 32'(drop_err), 32'd0);
    check_eq("start_max_idx", 32'(max_idx), 32'd0);
    check_eq("start_max_val", 32'(max_val), 32'd0);
    seen = 1'b0;
    for (int t = 0; t < 6; t++) begin
      seen |= max_valid;
      @(negedge clk);
    end
    check_eq("start_no_max", 32'(seen), 32'd0);

    // Fresh frame; phase 0 coincides with a bias write that it must not see.
    res_ready = 1'b1;
    b_wen = 1'b1; b_addr = 3'd0; b_wdata = 24'd50;
    din_valid = 1'b1; din_phase = 3'd0; din = 24'd100;
    @(negedge clk);
    b_wen = 1'b0; din_valid = 1'b0;
    exp_q.push_back(24'd100);
    for (int i = 1; i < 8; i++) begin
      send(3'(i), DW'(1000 + i));
      exp_q.push_back(DW'(1000 + i));
    end
    drain(1'b0, 3'd7, DW'(1007));

    // Phase 6 is out of range only for the NOUT=4 instance.
    pulse_start();
    send(3'd6, 24'd1);
    check_eq("n4_range_drop", 32'(n4_drop_err), 32'd1);
    check_eq("n8_no_drop", 32'(drop_err), 32'd0);
    pulse_start();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
